fmdsp_iter_mac: RTL
===================

Name: fmdsp_iter_mac

Overview:
- Parametrised multi-precision multiply-accumulate unit built on a single W×W unsigned core multiplier with PIPES internal register stages.
- Wide products are formed iteratively: 1, 2 or 4 partial-product passes are issued through the core, one per cycle, then shift-added into the product.
- The completed product is folded into an ACC_W accumulator with an optional pre-shift.
- Sits beside the fixed-width DSP datapath as the width-generic, handshaked successor for MAC use.

Parameters:
- W, 8, core multiplier operand width; full operands are 2W bits.
- PIPES, 2, register stages inside the core multiplier (0 allowed).
- ACC_W, 4W+8 (40), accumulator/output width; must be ≥ 4W.
- SH_UNIT, 4, bits per step of the accumulator pre-shift.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  2  0: a[W-1:0]×b[W-1:0] (1 pass); 1: a[2W-1:0]×b[W-1:0] (2 passes); 2: a×b full 2W×2W (4 passes); 3: illegal.
- mac  in  1  1: accumulate onto previous result; 0: overwrite.
- sh  in  2  accumulator pre-shift, sh*SH_UNIT bits left.
- a  in  2W  multiplicand.
- b  in  2W  multiplier.
- busy  out  1  high from the cycle after acceptance until valid.
- valid  out  1  one-cycle pulse; out updated on that cycle.
- err  out  1  one-cycle pulse for start with mode=3.
- out  out  ACC_W  accumulator value.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, valid and err at 0; out/acc at 0; operand, pass-count and pipeline registers cleared. Reset mid-operation aborts the operation with no valid pulse.
- Acceptance:
  - start=1 in IDLE with mode≠3 at edge E0 captures a, b, mode, mac and sh.
  - Later changes on these inputs have no effect until the next acceptance.
  - start while busy is ignored, with no queueing.
  - start with mode=3 in IDLE: err=1 for the following cycle, state stays IDLE, acc unchanged.
- FSM:
  - IDLE →(accept) ISSUE.
  - ISSUE issues one partial product per cycle for P cycles (P=1/2/4), then moves to DRAIN.
  - DRAIN waits PIPES cycles, then moves to DONE.
  - DONE lasts one cycle and returns to IDLE.
- Pass order and weights:
  - Notation: a0=a[W-1:0], a1=a[2W-1:W], b0, b1 likewise.
  - Mode 0: a0b0, weight 0.
  - Mode 1: a0b0 (weight 0), then a1b0 (weight W).
  - Mode 2: a0b0 (0), a1b0 (W), a0b1 (W), a1b1 (2W).
- Product register:
  - 4W bits; cleared at acceptance.
  - Each core result is added at its weight as it emerges from the pipeline.
  - Unsigned arithmetic; no overflow is possible.
- Completion (entering DONE):
  - acc ← ((mac ? acc << (sh*SH_UNIT) : 0) + product) mod 2^ACC_W.
  - Bits shifted above ACC_W are discarded silently.
  - out = acc, registered.
- Latency: with acceptance at edge E0, acc updates and valid=1 on the cycle after edge E0+P+PIPES+1.
  - PIPES=2: mode 0 → 4 edges, mode 1 → 5, mode 2 → 7.
- busy=1 from edge E0 through the edge on which valid rises; busy=0 during the valid cycle.
- Back-to-back: start may be asserted during the valid cycle and is accepted at that edge. Maximum throughput is one operation per P+PIPES+2 cycles.
- out holds its value between operations; mac=0 with a=b=0 clears it to 0.

Test Plan:
1. Defaults, mode 0, mac=0, a=0x00FF, b=0x00FF, start one cycle → valid exactly 4 edges after acceptance; out=0xFE01; busy high for 4 cycles; upper operand bits ignored (a=0xABFF gives the same result).
2. Mode 1, a=0x1234, b=0xAB56 (b1 ignored), mac=0 → out=0x61D78 after 5 edges; mode 2, a=0xFFFF, b=0xFFFF → out=0xFFFE0001 after 7 edges.
3. Accumulation, SH_UNIT=4:
   - mode 0, mac=0, a=3, b=4 → out=0x0C.
   - then mac=1, sh=1, a=5, b=6 → out=0xDE.
   - then mac=1, sh=0, a=b=0 → out stays 0xDE.
4. Truncation: mode 2, a=b=0xFFFF, mac=0 → 0xFFFE0001; then mode 0, mac=1, sh=3, a=b=0 → out=0xFFE0001000 (bits above 40 dropped).
5. Handshake:
   - start held high continuously in mode 0 → an operation every 5 cycles.
   - input changes while busy do not alter the result.
   - start with mode=3 → err pulse, no busy, out unchanged.
6. Reset: assert rst_n=0 mid-ISSUE of a mode 2 op → outputs 0 immediately (async); no valid after release; next mode 0 op 2×3 gives out=6 with correct latency.
7. Random regression, 200 ops per mode with mac randomised → out matches the reference model on every valid.

Source files
------------

// File: rtl/fmdsp_iter_mac.sv
// Multi-precision unsigned MAC: wide products are built from 1, 2 or 4 passes through
// one pipelined WxW core multiplier, then folded into a pre-shifted accumulator.
module fmdsp_iter_mac #(
  parameter int unsigned W       = 8,
  parameter int unsigned PIPES   = 2,
  parameter int unsigned ACC_W   = 4 * W + 8,
  parameter int unsigned SH_UNIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             mac,
  input  logic [1:0]       sh,
  input  logic [2*W-1:0]   a,
  input  logic [2*W-1:0]   b,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [ACC_W-1:0] out
);

  localparam int unsigned CntW = (PIPES < 4) ? 2 : $clog2(PIPES + 1);
  localparam int unsigned StW  = 2 * W + 3;
  localparam logic [CntW-1:0] DrainLast = CntW'(PIPES > 0 ? PIPES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*W-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]         mode_q, mode_d, sh_q, sh_d;
  logic               mac_q, mac_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [4*W-1:0]     prod_q, prod_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               valid_q, valid_d, err_q, err_d;

  // Pass index bit 0 selects a1, bit 1 selects b1; weight in units of W is their sum.
  logic [W-1:0]       op_a, op_b;
  logic [1:0]         op_w;
  logic [CntW-1:0]    last_idx;
  logic [2*W-1:0]     core_p;

  always_comb begin
    op_a = cnt_q[0] ? a_q[2*W-1:W] : a_q[W-1:0];
    op_b = cnt_q[1] ? b_q[2*W-1:W] : b_q[W-1:0];
    op_w = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
    unique case (mode_q)
      2'd0:    last_idx = CntW'(0);
      2'd1:    last_idx = CntW'(1);
      default: last_idx = CntW'(3);
    endcase
  end

  assign core_p = (2 * W)'(op_a) * (2 * W)'(op_b);

  // Core pipeline carries {issue valid, weight, partial product}.
  logic [StW-1:0] st_in, st_out;
  assign st_in = {state_q == StIssue, op_w, core_p};

  if (PIPES == 0) begin : g_nopipe
    assign st_out = st_in;
  end else begin : g_pipe
    logic [StW-1:0] st_q [PIPES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(PIPES); i++) st_q[i] <= '0;
      end else begin
        st_q[0] <= st_in;
        for (int i = 1; i < int'(PIPES); i++) st_q[i] <= st_q[i-1];
      end
    end
    assign st_out = st_q[PIPES-1];
  end

  logic             pipe_vld;
  logic [1:0]       pipe_w;
  logic [2*W-1:0]   pipe_p;
  logic [4*W-1:0]   pipe_term;

  assign {pipe_vld, pipe_w, pipe_p} = st_out;
  assign pipe_term = (4 * W)'(pipe_p) << (32'(pipe_w) * W);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    mac_d   = mac_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (pipe_vld) prod_d = prod_q + pipe_term;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == 2'd3) begin
            err_d = 1'b1;
          end else begin
            a_d     = a;
            b_d     = b;
            mode_d  = mode;
            mac_d   = mac;
            sh_d    = sh;
            cnt_d   = '0;
            prod_d  = '0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == last_idx) begin
          cnt_d   = '0;
          state_d = (PIPES == 0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        // Last partial product landed on the edge entering this state.
        acc_d   = (mac_q ? (acc_q << (32'(sh_q) * SH_UNIT)) : '0) + ACC_W'(prod_q);
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      mac_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      mac_q   <= mac_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = valid_q;
  assign err   = err_q;
  assign out   = acc_q;

endmodule
